// File: rtl/mc_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and the memory.
`timescale 1ns/1ps

interface mc_fetch_unit_if;
  logic        valid;
  logic [31:0] addr;
  logic        ready;
  logic        data_ok;
  logic [31:0] data;

  modport master (output valid, addr, input ready, data_ok, data);
  modport slave  (input valid, addr, output ready, data_ok, data);
endinterface

// File: rtl/mc_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: PC, IR and one memory read per fetch.
//
// state | meaning
// IDLE  | no fetch in flight; fetch_go accepted here only
// REQ   | read request presented, waiting for the address to be accepted
// WAIT  | address accepted, waiting for read data
`timescale 1ns/1ps

module mc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_go,
  input  logic                  pc_we,
  input  logic [31:0]           pc_wdata,
  mc_fetch_unit_if.master       imem,
  output logic [31:0]           ir,
  output logic [5:0]            op,
  output logic [5:0]            func,
  output logic                  ir_valid,
  output logic [31:0]           ir_pc,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  fetch_busy,
  output logic                  adel
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;
  logic   go_ok;
  logic   go_bad;
  logic   load;
  // Set once the PC is redirected during a fetch; the completing load then
  // must not add 4 on top of the written target.
  logic   redirected;

  assign op         = ir[31:26];
  assign func       = ir[5:0];
  assign pc_plus4   = pc + 32'd4;
  assign fetch_busy = (state != IDLE);
  assign imem.valid = (state == REQ);
  // A redirect during REQ must not disturb the address already presented.
  assign imem.addr  = (state == REQ) ? ir_pc : pc;

  // Next-state and per-cycle strobes.
  always_comb begin
    state_next = state;
    go_ok      = 1'b0;
    go_bad     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_go) begin
          if (pc[1:0] == 2'b00) begin
            go_ok      = 1'b1;
            state_next = REQ;
          end else begin
            go_bad     = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem.ready) begin
          if (imem.data_ok) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem.data_ok) begin
          load       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // PC update: redirect wins over the post-fetch increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   pc <= RESET_PC;
    else if (pc_we)              pc <= pc_wdata;
    else if (load && !redirected) pc <= pc_plus4;
  end

  // Track whether the PC was written since the current fetch was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          redirected <= 1'b0;
    else if (go_ok)                     redirected <= pc_we;
    else if (pc_we && state != IDLE)    redirected <= 1'b1;
  end

  // Instruction register, its tag and the misaligned-fetch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      adel     <= 1'b0;
    end else begin
      adel <= go_bad;
      if (go_ok || go_bad) ir_valid <= 1'b0;
      if (go_ok)           ir_pc    <= pc;
      if (load) begin
        ir       <= imem.data;
        ir_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Self-checking bench for mc_fetch_unit.
`timescale 1ns/1ps

module tb_mc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_go;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        ir_valid;
  logic [31:0] ir_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_busy;
  logic        adel;

  mc_fetch_unit_if imem ();

  mc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_go   (fetch_go),
    .pc_we      (pc_we),
    .pc_wdata   (pc_wdata),
    .imem       (imem),
    .ir         (ir),
    .op         (op),
    .func       (func),
    .ir_valid   (ir_valid),
    .ir_pc      (ir_pc),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_busy (fetch_busy),
    .adel       (adel)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    bit          set_pc;
    logic [31:0] start;
    int          rw;
    int          dw;
    int          we_at;
    logic [31:0] wdata;
    logic [31:0] word;
    bit          hold;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string nm, input bit sp, input logic [31:0] st,
                              input int rw, input int dw, input int we_at,
                              input logic [31:0] wd, input logic [31:0] wo,
                              input bit hold, input logic [31:0] epc, input int elat);
    vec_t v;
    v.name = nm; v.set_pc = sp; v.start = st; v.rw = rw; v.dw = dw; v.we_at = we_at;
    v.wdata = wd; v.word = wo; v.hold = hold; v.exp_pc = epc; v.exp_lat = elat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic quiet();
    fetch_go = 1'b0; pc_we = 1'b0; imem.ready = 1'b0; imem.data_ok = 1'b0;
  endtask

  // Starts and ends just after a falling edge.
  task automatic set_pc(input logic [31:0] v);
    quiet();
    pc_we = 1'b1; pc_wdata = v;
    @(posedge clk); @(negedge clk);
    pc_we = 1'b0;
    chk("set_pc", pc, v);
  endtask

  // One fetch with rw cycles of ready low and dw cycles of WAIT without data.
  task automatic run_fetch(input string nm, input logic [31:0] exp_addr,
                           input int rw, input int dw, input int we_at,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input bit hold, input logic [31:0] exp_pc, input int exp_lat);
    int last, lat, n, reqs;
    last = rw + dw + 1; lat = -1; n = 0; reqs = 0;
    for (int k = 0; k <= last; k++) begin
      fetch_go = (k == 0) || hold;
      pc_we    = (k == we_at);
      pc_wdata = wdata;
      if (k == 0)           imem.ready = 1'($urandom);
      else if (k <= rw)     imem.ready = 1'b0;
      else if (k == rw + 1) imem.ready = 1'b1;
      else                  imem.ready = 1'($urandom);
      imem.data_ok = (k == last) || (k == 0 && $urandom_range(0, 1) == 1);
      imem.data    = (k == last) ? word : $urandom;
      @(posedge clk); @(negedge clk);
      n++;
      if (lat < 0 && ir_valid) lat = n;
      if (imem.valid) reqs++;
      if (k < last) begin
        chk({nm, ".valid"}, imem.valid, (k <= rw) ? 1 : 0);
        if (k <= rw) chk({nm, ".addr"}, imem.addr, exp_addr);
        chk({nm, ".busy"}, fetch_busy, 1);
      end
    end
    quiet();
    while (lat < 0 && n < last + 10) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (ir_valid) lat = n;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".reqs"}, reqs, rw + 1);
    chk({nm, ".ir"}, ir, word);
    chk({nm, ".op"}, op, word[31:26]);
    chk({nm, ".func"}, func, word[5:0]);
    chk({nm, ".ir_valid"}, ir_valid, 1);
    chk({nm, ".ir_pc"}, ir_pc, exp_addr);
    chk({nm, ".pc"}, pc, exp_pc);
    chk({nm, ".pc_plus4"}, pc_plus4, exp_pc + 32'd4);
    chk({nm, ".busy_end"}, fetch_busy, 0);
    chk({nm, ".valid_end"}, imem.valid, 0);
    chk({nm, ".adel"}, adel, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] last_word;
    logic [31:0] mdl_pc;
    logic [31:0] exp_pc;
    logic [31:0] wd;
    int rw, dw, we_at;

    reset = 1'b1; quiet(); pc_wdata = '0; imem.data = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst.pc", pc, RST_PC);
    chk("rst.pc_plus4", pc_plus4, 32'hBFC0_0004);
    chk("rst.ir", ir, 0);
    chk("rst.ir_pc", ir_pc, 0);
    chk("rst.ir_valid", ir_valid, 0);
    chk("rst.adel", adel, 0);
    chk("rst.busy", fetch_busy, 0);
    chk("rst.valid", imem.valid, 0);

    vq.push_back(mk("zero_wait",  0, RST_PC,        0, 0, -1, '0,            32'h2008_0005, 0, 32'hBFC0_0004, 2));
    vq.push_back(mk("slow_mem",   1, 32'h0000_2000, 3, 2, -1, '0,            32'h8C41_0004, 0, 32'h0000_2004, 7));
    vq.push_back(mk("we_in_wait", 1, 32'h0000_3000, 1, 2,  3, 32'h0040_0100, 32'h1000_FFFF, 0, 32'h0040_0100, 5));
    vq.push_back(mk("after_redir",0, 32'h0040_0100, 0, 1, -1, '0,            32'h0000_0020, 0, 32'h0040_0104, 3));
    vq.push_back(mk("we_in_req",  1, 32'h0000_4000, 2, 0,  1, 32'h0000_8000, 32'h2402_0001, 0, 32'h0000_8000, 4));
    vq.push_back(mk("we_at_load", 1, 32'h0000_5000, 0, 0,  1, 32'h0000_9000, 32'h0800_0040, 0, 32'h0000_9000, 2));
    vq.push_back(mk("we_at_go",   1, 32'h0000_6000, 1, 0,  0, 32'h0000_A000, 32'h0C00_0010, 0, 32'h0000_A000, 3));
    vq.push_back(mk("wrap",       1, 32'hFFFF_FFFC, 0, 0, -1, '0,            32'h3C1D_1234, 0, 32'h0000_0000, 2));
    vq.push_back(mk("hold_go",    1, 32'h0000_7000, 2, 1, -1, '0,            32'hAC22_0008, 1, 32'h0000_7004, 5));

    foreach (vq[i]) begin
      if (vq[i].set_pc) set_pc(vq[i].start);
      run_fetch(vq[i].name, vq[i].start, vq[i].rw, vq[i].dw, vq[i].we_at,
                vq[i].wdata, vq[i].word, vq[i].hold, vq[i].exp_pc, vq[i].exp_lat);
      last_word = vq[i].word;
    end

    // Stray read data in IDLE must not touch the IR.
    quiet();
    imem.data_ok = 1'b1; imem.data = 32'hDEAD_BEEF;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    quiet();
    chk("stray.ir", ir, last_word);
    chk("stray.ir_valid", ir_valid, 1);
    chk("stray.busy", fetch_busy, 0);

    // Misaligned PC: no request, single adel pulse.
    set_pc(32'h0040_0102);
    fetch_go = 1'b1;
    @(posedge clk); @(negedge clk);
    fetch_go = 1'b0;
    chk("adel.pulse", adel, 1);
    chk("adel.valid", imem.valid, 0);
    chk("adel.busy", fetch_busy, 0);
    chk("adel.ir_valid", ir_valid, 0);
    chk("adel.pc", pc, 32'h0040_0102);
    @(posedge clk); @(negedge clk);
    chk("adel.drop", adel, 0);
    chk("adel.valid2", imem.valid, 0);

    // Reset while the request is outstanding.
    set_pc(32'h0000_0100);
    fetch_go = 1'b1;
    @(posedge clk); @(negedge clk);
    quiet();
    chk("rreq.valid_before", imem.valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rreq.valid", imem.valid, 0);
    chk("rreq.busy", fetch_busy, 0);
    chk("rreq.pc", pc, RST_PC);
    @(negedge clk);
    reset = 1'b0;

    // Reset during WAIT; the late data must be dropped.
    fetch_go = 1'b1;
    @(posedge clk); @(negedge clk);
    fetch_go = 1'b0; imem.ready = 1'b1; imem.data_ok = 1'b0;
    @(posedge clk); @(negedge clk);
    imem.ready = 1'b0;
    chk("rwait.busy_before", fetch_busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("rwait.busy", fetch_busy, 0);
    chk("rwait.pc", pc, RST_PC);
    chk("rwait.ir_valid", ir_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    imem.data_ok = 1'b1; imem.data = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    quiet();
    chk("rwait.late_ir", ir, 0);
    chk("rwait.late_valid", ir_valid, 0);
    chk("rwait.late_pc", pc, RST_PC);
    chk("rwait.late_busy", fetch_busy, 0);

    // Random fetches against a transaction-level PC model.
    mdl_pc = 32'h0000_1000;
    set_pc(mdl_pc);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        mdl_pc = $urandom & 32'hFFFF_FFFC;
        set_pc(mdl_pc);
      end
      rw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      we_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rw + dw + 1) : -1;
      wd = $urandom & 32'hFFFF_FFFC;
      exp_pc = (we_at >= 0) ? wd : mdl_pc + 32'd4;
      run_fetch("rnd", mdl_pc, rw, dw, we_at, wd, $urandom, 1'($urandom),
                exp_pc, rw + dw + 2);
      mdl_pc = exp_pc;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
